// File: rtl/test_ram_arb_if.sv
// Command/response bundle between one requester and the TEST_RAM arbiter.
// The requester drives the command side; the arbiter returns ready and read data.
interface test_ram_arb_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   logic                  valid;
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  ready;
   logic                  rvalid;
   logic [DATA_WIDTH-1:0] rdata;

   modport master (output valid, we, addr, wdata, input ready, rvalid, rdata);
   modport slave  (input valid, we, addr, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/test_ram_arb.sv
// Two-master arbiter for the simple dual-port TEST_RAM: independent round-robin
// write and read arbiters with bounded bursts, write wins a same-address clash.

module test_ram_arb_port #(
   parameter int MAX_BURST = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] cand,
   input  logic       hold,
   output logic       any,
   output logic       sel
);
   localparam int CW = $clog2(MAX_BURST + 1);

   logic          last;
   logic [CW-1:0] cnt;
   logic          keep;

   // cnt==0 means the previous run was broken, so contention falls back to
   // plain round-robin; this is what gives m0 first priority out of reset.
   assign any  = |cand;
   assign keep = (cnt != '0) && (cnt < CW'(MAX_BURST));

   always_comb begin
      sel = 1'b0;
      case (cand)
         2'b10:   sel = 1'b1;
         2'b11:   sel = keep ? last : ~last;
         default: sel = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last <= 1'b1;
         cnt  <= '0;
      end else if (!hold) begin
         if (!any) begin
            cnt <= '0;
         end else if (sel == last) begin
            if (cnt != CW'(MAX_BURST)) cnt <= cnt + CW'(1);
         end else begin
            last <= sel;
            cnt  <= CW'(1);
         end
      end
   end
endmodule

module test_ram_arb #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BURST  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   test_ram_arb_if.slave         m0,
   test_ram_arb_if.slave         m1,
   output logic                  ram_wr_en,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr,
   output logic [DATA_WIDTH-1:0] ram_wr_data,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   input  logic [DATA_WIDTH-1:0] ram_rd_data
);
   localparam int WR = 0;
   localparam int RD = 1;

   logic [1:0]                 valid, we;
   logic [1:0][ADDR_WIDTH-1:0] addr;
   logic [1:0][DATA_WIDTH-1:0] wdata;
   logic [1:0][1:0]            cand;
   logic [1:0]                 any, sel, hold, ready;
   logic                       wr_acc, rd_acc, hazard;

   logic                  rpend, rsel;
   logic [ADDR_WIDTH-1:0] rd_addr_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   assign valid = {m1.valid, m0.valid};
   assign we    = {m1.we, m0.we};
   assign addr  = {m1.addr, m0.addr};
   assign wdata = {m1.wdata, m0.wdata};

   assign cand[WR] = valid & we;
   assign cand[RD] = valid & ~we;

   for (genvar p = 0; p < 2; p++) begin : g_port
      test_ram_arb_port #(.MAX_BURST(MAX_BURST)) u_arb (
         .clk  (clk),
         .rst  (rst),
         .cand (cand[p]),
         .hold (hold[p]),
         .any  (any[p]),
         .sel  (sel[p])
      );
   end

   // A blocked read freezes its arbiter so the same master retries with
   // its burst position intact.
   assign wr_acc   = any[WR] & ~rst;
   assign hazard   = any[RD] & wr_acc & (addr[sel[RD]] == addr[sel[WR]]);
   assign rd_acc   = any[RD] & ~hazard & ~rst;
   assign hold[WR] = 1'b0;
   assign hold[RD] = hazard;

   assign ready[0] = (wr_acc & ~sel[WR]) | (rd_acc & ~sel[RD]);
   assign ready[1] = (wr_acc &  sel[WR]) | (rd_acc &  sel[RD]);

   assign ram_wr_en   = wr_acc;
   assign ram_wr_addr = any[WR] ? addr[sel[WR]]  : addr[0];
   assign ram_wr_data = any[WR] ? wdata[sel[WR]] : wdata[0];
   assign ram_rd_addr = any[RD] ? addr[sel[RD]]  : rd_addr_q;

   // RAM read output is combinational off ram_rd_addr, so it is captured at
   // the accept edge; that frees the read port for a back-to-back read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rpend     <= 1'b0;
         rsel      <= 1'b0;
         rd_addr_q <= '0;
         rdata_q   <= '0;
      end else begin
         rpend <= rd_acc;
         if (rd_acc) begin
            rsel      <= sel[RD];
            rd_addr_q <= addr[sel[RD]];
            rdata_q   <= ram_rd_data;
         end
      end
   end

   assign m0.ready  = ready[0];
   assign m1.ready  = ready[1];
   assign m0.rvalid = rpend & ~rsel;
   assign m1.rvalid = rpend &  rsel;
   assign m0.rdata  = rdata_q;
   assign m1.rdata  = rdata_q;
endmodule

// File: tb/tb_test_ram_arb.sv
// Bench for test_ram_arb: queue-driven masters, behavioural RAM, and a per-cycle
// arbitration/read-return model plus directed literal expectations.
module tb_test_ram_arb;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam int MAX_BURST = 4;

   typedef struct {
      bit            we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } cmd_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   test_ram_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_if ();
   test_ram_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_if ();

   logic          ram_wr_en;
   logic [AW-1:0] ram_wr_addr, ram_rd_addr;
   logic [DW-1:0] ram_wr_data, ram_rd_data;

   test_ram_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MAX_BURST)) dut (
      .clk         (clk),
      .rst         (rst),
      .m0          (m0_if),
      .m1          (m1_if),
      .ram_wr_en   (ram_wr_en),
      .ram_wr_addr (ram_wr_addr),
      .ram_wr_data (ram_wr_data),
      .ram_rd_addr (ram_rd_addr),
      .ram_rd_data (ram_rd_data)
   );

   // TEST_RAM stand-in: registered write, unregistered read
   logic [DW-1:0] mem [256];
   always @(posedge clk) if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
   assign ram_rd_data = mem[ram_rd_addr];

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic cmd_t mk(input bit we, input int addr, input logic [DW-1:0] d);
      cmd_t c;
      c.we   = we;
      c.addr = addr[AW-1:0];
      c.data = d;
      return c;
   endfunction

   // ---------------- masters ----------------
   cmd_t q0[$], q1[$];
   bit   a0, a1;

   initial begin : drv0
      m0_if.valid = 1'b0; m0_if.we = 1'b0; m0_if.addr = '0; m0_if.wdata = '0;
      forever begin
         @(negedge clk); a0 = m0_if.valid && m0_if.ready;
         @(posedge clk); #1;
         if (a0) q0.delete(0);
         if (q0.size() != 0) begin
            m0_if.valid = 1'b1; m0_if.we = q0[0].we; m0_if.addr = q0[0].addr; m0_if.wdata = q0[0].data;
         end else m0_if.valid = 1'b0;
      end
   end

   initial begin : drv1
      m1_if.valid = 1'b0; m1_if.we = 1'b0; m1_if.addr = '0; m1_if.wdata = '0;
      forever begin
         @(negedge clk); a1 = m1_if.valid && m1_if.ready;
         @(posedge clk); #1;
         if (a1) q1.delete(0);
         if (q1.size() != 0) begin
            m1_if.valid = 1'b1; m1_if.we = q1[0].we; m1_if.addr = q1[0].addr; m1_if.wdata = q1[0].data;
         end else m1_if.valid = 1'b0;
      end
   end

   // ---------------- model ----------------
   int            m_wlast, m_wrun, m_rlast, m_rrun, m_psel;
   bit            m_pend;
   logic [DW-1:0] m_pdata;
   logic [AW-1:0] m_raq;
   logic [DW-1:0] shadow [256];

   // Under contention the master on an unbroken run shorter than the burst
   // limit continues; otherwise the port goes to the master not granted last.
   function automatic int pick(input bit [1:0] c, input int last, input int run);
      if (c == 2'b11) return (run > 0 && run < MAX_BURST) ? last : 1 - last;
      return c[1] ? 1 : 0;
   endfunction

   always @(negedge clk) begin : model
      bit [1:0]      wc, rc;
      int            ww, rw;
      bit            wacc, rany, haz, racc;
      logic [AW-1:0] wa, ra;
      logic [DW-1:0] wd;
      if (rst) begin
         chk("rst_m0_ready", 32'(m0_if.ready), 0);
         chk("rst_m1_ready", 32'(m1_if.ready), 0);
         chk("rst_wr_en", 32'(ram_wr_en), 0);
         chk("rst_rvalid", 32'(m0_if.rvalid | m1_if.rvalid), 0);
         m_wlast = 1; m_wrun = 0; m_rlast = 1; m_rrun = 0;
         m_pend = 1'b0; m_psel = 0; m_raq = '0;
      end else begin
         wc   = {m1_if.valid & m1_if.we, m0_if.valid & m0_if.we};
         rc   = {m1_if.valid & ~m1_if.we, m0_if.valid & ~m0_if.we};
         ww   = pick(wc, m_wlast, m_wrun);
         rw   = pick(rc, m_rlast, m_rrun);
         wacc = (wc != 2'b00);
         rany = (rc != 2'b00);
         wa   = (ww == 1) ? m1_if.addr  : m0_if.addr;
         wd   = (ww == 1) ? m1_if.wdata : m0_if.wdata;
         ra   = (rw == 1) ? m1_if.addr  : m0_if.addr;
         haz  = rany && wacc && (ra == wa);
         racc = rany && !haz;
         chk("m0_ready", 32'(m0_if.ready), 32'((wacc && ww == 0) || (racc && rw == 0)));
         chk("m1_ready", 32'(m1_if.ready), 32'((wacc && ww == 1) || (racc && rw == 1)));
         chk("wr_en", 32'(ram_wr_en), 32'(wacc));
         if (wacc) begin
            chk("wr_addr", 32'(ram_wr_addr), 32'(wa));
            chk("wr_data", ram_wr_data, wd);
         end
         chk("rd_addr", 32'(ram_rd_addr), 32'(rany ? ra : m_raq));
         chk("m0_rvalid", 32'(m0_if.rvalid), 32'(m_pend && m_psel == 0));
         chk("m1_rvalid", 32'(m1_if.rvalid), 32'(m_pend && m_psel == 1));
         if (m_pend && m_psel == 0) chk("m0_rdata", m0_if.rdata, m_pdata);
         if (m_pend && m_psel == 1) chk("m1_rdata", m1_if.rdata, m_pdata);
         // what the coming edge commits
         m_pend = racc;
         if (racc) begin m_psel = rw; m_pdata = shadow[ra]; m_raq = ra; end
         if (wacc) shadow[wa] = wd;
         if (!wacc) m_wrun = 0;
         else if (ww == m_wlast) m_wrun = (m_wrun < MAX_BURST) ? m_wrun + 1 : MAX_BURST;
         else begin m_wlast = ww; m_wrun = 1; end
         if (!haz) begin
            if (!racc) m_rrun = 0;
            else if (rw == m_rlast) m_rrun = (m_rrun < MAX_BURST) ? m_rrun + 1 : MAX_BURST;
            else begin m_rlast = rw; m_rrun = 1; end
         end
      end
   end

   // ---------------- monitors ----------------
   int            wlog[$];
   logic [DW-1:0] rq0[$], rq1[$];
   bit            conc_on = 1'b0, rv_on = 1'b0;
   int            conc_cyc = 0, conc_stall = 0, rv_seen = 0;

   always @(negedge clk) begin : mon
      if (!rst && ram_wr_en) wlog.push_back((m1_if.ready && m1_if.we) ? 1 : 0);
      if (m0_if.rvalid) rq0.push_back(m0_if.rdata);
      if (m1_if.rvalid) rq1.push_back(m1_if.rdata);
      if (conc_on && m0_if.valid && m1_if.valid) begin
         conc_cyc++;
         if (!(m0_if.ready && m1_if.ready)) conc_stall++;
      end
      if (rv_on && (m0_if.rvalid || m1_if.rvalid)) rv_seen++;
   end

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0 || m0_if.valid || m1_if.valid ||
              m0_if.rvalid || m1_if.rvalid) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) begin
         n_vec++; n_bad++;
         $display("FAIL %s: still busy after %0d cycles, want idle", name, n);
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
   endtask

   // ---------------- directed sequence ----------------
   initial begin : main
      int errs;
      q0.push_back(mk(1, 8'h10, 32'hA0A0A0A0));
      q1.push_back(mk(1, 8'h11, 32'hB1B1B1B1));
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_both_valid_m0_ready", 32'(m0_if.ready), 0);
      chk("rst_both_valid_m1_ready", 32'(m1_if.ready), 0);
      chk("rst_both_valid_wr_en", 32'(ram_wr_en), 0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("first_grant_m0", 32'(m0_if.ready), 1);
      chk("first_grant_m1_waits", 32'(m1_if.ready), 0);
      chk("first_wr_addr", 32'(ram_wr_addr), 32'h10);
      @(negedge clk);
      chk("second_grant_m1", 32'(m1_if.ready), 1);
      chk("second_wr_data", ram_wr_data, 32'hB1B1B1B1);
      wait_idle("reset_release", 20);

      rq0.delete();
      q0.push_back(mk(1, 0, 32'hFFFFFFFF));
      q0.push_back(mk(0, 0, 32'h0));
      wait_idle("single_rw", 20);
      chk("single_rd_count", 32'(rq0.size()), 1);
      if (rq0.size() > 0) chk("single_rd_data", rq0[0], 32'hFFFFFFFF);

      do_reset();
      wlog.delete();
      for (int i = 0; i < 256; i++) begin
         q0.push_back(mk(1, i, 32'hFFFFFFFF - 32'(i)));
         q1.push_back(mk(1, i, 32'hFFFFFFFF - 32'(i)));
      end
      wait_idle("contention", 1200);
      chk("wr_log_len", 32'(wlog.size()), 512);
      if (wlog.size() > 8) begin
         chk("wr_grant_0", 32'(wlog[0]), 0);
         chk("wr_grant_4", 32'(wlog[4]), 1);
         chk("wr_grant_8", 32'(wlog[8]), 0);
      end
      errs = 0;
      for (int i = 0; i < wlog.size(); i++) if (wlog[i] != (i / 4) % 2) errs++;
      chk("wr_rr_pattern_errs", 32'(errs), 0);

      rq0.delete();
      for (int i = 0; i < 256; i++) q0.push_back(mk(0, i, 32'h0));
      wait_idle("readback", 600);
      chk("readback_count", 32'(rq0.size()), 256);
      errs = 0;
      for (int i = 0; i < rq0.size(); i++) if (rq0[i] !== 32'hFFFFFFFF - 32'(i)) errs++;
      chk("readback_errs", 32'(errs), 0);

      rq1.delete();
      conc_cyc = 0; conc_stall = 0; conc_on = 1'b1;
      for (int i = 0; i < 128; i++) begin
         q0.push_back(mk(1, i, 32'h1000 + 32'(i)));
         q1.push_back(mk(0, 8'h80 + i, 32'h0));
      end
      wait_idle("concurrent", 400);
      conc_on = 1'b0;
      chk("conc_stalls", 32'(conc_stall), 0);
      chk("conc_cycles", 32'(conc_cyc), 128);
      chk("conc_rd_count", 32'(rq1.size()), 128);
      errs = 0;
      for (int i = 0; i < rq1.size(); i++) if (rq1[i] !== 32'hFFFFFFFF - 32'(128 + i)) errs++;
      chk("conc_rd_errs", 32'(errs), 0);

      rq1.delete();
      q0.push_back(mk(1, 8'h40, 32'h12345678));
      q1.push_back(mk(0, 8'h40, 32'h0));
      @(negedge clk);
      chk("haz_m0_write", 32'(m0_if.ready), 1);
      chk("haz_m1_blocked", 32'(m1_if.ready), 0);
      @(negedge clk);
      chk("haz_m1_retry", 32'(m1_if.ready), 1);
      chk("haz_retry_no_write", 32'(ram_wr_en), 0);
      wait_idle("hazard", 20);
      chk("haz_rd_count", 32'(rq1.size()), 1);
      if (rq1.size() > 0) chk("haz_rd_data", rq1[0], 32'h12345678);

      rv_seen = 0;
      q1.push_back(mk(0, 8'h90, 32'h0));
      @(negedge clk);
      chk("rstrd_accept", 32'(m1_if.ready), 1);
      @(posedge clk); #1 rst = 1'b1; rv_on = 1'b1;
      repeat (2) @(negedge clk);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      rv_on = 1'b0;
      chk("rstrd_no_rvalid", 32'(rv_seen), 0);
      rq1.delete();
      q1.push_back(mk(0, 8'h90, 32'h0));
      wait_idle("post_reset_read", 20);
      chk("rstrd_rd_count", 32'(rq1.size()), 1);
      if (rq1.size() > 0) chk("rstrd_ram_kept", rq1[0], 32'hFFFFFF6F);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: time limit reached before the sequence ended");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
      $fatal(1);
   end
endmodule
